// File: rtl/mult_sched_pkg.sv
// Shared types and width helpers for the round-robin multiplier scheduler.
// Imported by the arbiter and the scheduler top.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int prod_width(input int dw);
        return 2 * dw;
    endfunction

    function automatic int tmo_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/mult_rr_arbiter.sv
// Combinational rotating-priority picker: first request at or after i_ptr.
// Produces a one-hot grant, its index and an any-request flag.
import mult_sched_pkg::*;

module mult_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    localparam int SW = IDX_W + 1;

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr and offset are both below NUM_REQ, one wrap suffices
            w_sum = {1'b0, i_ptr} + SW'(i);
            if (w_sum >= SW'(NUM_REQ)) begin
                w_sum = w_sum - SW'(NUM_REQ);
            end
            w_pos = w_sum[IDX_W-1:0];
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_idx          = w_pos;
                o_grant[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one multi-cycle multiplier core between NUM_REQ requesters,
// round-robin arbitration, done timeout and per-requester responses.
import mult_sched_pkg::*;

module mult_rr_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]            req_signed,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [2*DATA_WIDTH-1:0]       rsp_product,
    output logic                          rsp_err,
    output logic                          mul_start,
    output logic [DATA_WIDTH-1:0]         mul_a,
    output logic [DATA_WIDTH-1:0]         mul_b,
    output logic                          mul_signed,
    input  logic                          mul_done,
    input  logic [2*DATA_WIDTH-1:0]       mul_product,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          jobs_done
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int PW = prod_width(DATA_WIDTH);
    localparam int TW = tmo_width(TIMEOUT_CYCLES);

    sched_state_t r_state;
    sched_state_t w_next;

    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_grant;
    logic [TW-1:0]         r_tmo;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_signed;
    logic [PW-1:0]         r_prod;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_jobs;

    logic [NUM_REQ-1:0]    w_grant;
    logic [IW-1:0]         w_idx;
    logic                  w_any;
    logic                  w_accept;
    logic                  w_rsp_hs;
    logic                  w_tmo_exp;
    logic [DATA_WIDTH-1:0] w_sel_a;
    logic [DATA_WIDTH-1:0] w_sel_b;
    logic                  w_sel_s;

    mult_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Expiry is the last counted WAIT cycle; a done on it still wins
    assign w_tmo_exp = (TIMEOUT_CYCLES != 0)
                    && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        w_sel_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel_a = req_a[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_b = req_b[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_s = req_signed[k];
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_rsp_hs = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_accept = 1'b1;
                    w_next   = ISSUE;
                end
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (mul_done || w_tmo_exp) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[r_grant]) begin
                    w_rsp_hs = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_ptr    <= '0;
            r_grant  <= '0;
            r_tmo    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_prod   <= '0;
            r_err    <= 1'b0;
            r_jobs   <= '0;
        end else begin
            if (w_accept) begin
                r_a      <= w_sel_a;
                r_b      <= w_sel_b;
                r_signed <= w_sel_s;
                r_grant  <= w_idx;
                r_ptr    <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
            end
            if (r_state == ISSUE) begin
                r_tmo <= '0;
            end else if (r_state == WAIT && !mul_done) begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (r_state == WAIT) begin
                if (mul_done) begin
                    r_prod <= mul_product;
                    r_err  <= 1'b0;
                end else if (w_tmo_exp) begin
                    r_prod <= '0;
                    r_err  <= 1'b1;
                end
            end
            if (w_rsp_hs) begin
                r_jobs <= r_jobs + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_state == RESP) begin
            rsp_valid[r_grant] = 1'b1;
        end
    end

    assign req_ready   = (r_state == IDLE) ? w_grant : '0;
    assign rsp_product = r_prod;
    assign rsp_err     = r_err;
    assign mul_start   = (r_state == ISSUE);
    assign mul_a       = r_a;
    assign mul_b       = r_b;
    assign mul_signed  = r_signed;
    assign busy        = (r_state != IDLE);
    assign jobs_done   = r_jobs;

endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Shares one multi-cycle multiplier core between NUM_REQ requesters.
- Arbitrates round-robin, captures the winner's operands and pulses start to the core.
- Waits for done, with a timeout, then returns the product to the winning requester.
- Sits between the register/AXI-facing front ends and the multiplier datapath inside the multiplication IP.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 32: operand width; product is 2*DATA_WIDTH.
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT before error; 0 disables the timeout.
- CNT_WIDTH, 32: width of the completed-job counter.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot accept.
- req_a  in  NUM_REQ*DATA_WIDTH  operand A, requester k at slice [k*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  operand B, same slicing.
- req_signed  in  NUM_REQ  1 = signed multiply.
- rsp_valid  out  NUM_REQ  one-hot response valid.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_product  out  2*DATA_WIDTH  shared response data.
- rsp_err  out  1  response is a timeout error.
- mul_start  out  1  one-cycle start pulse to the core.
- mul_a, mul_b  out  DATA_WIDTH each  held operands.
- mul_signed  out  1  held sign mode.
- mul_done  in  1  core completion pulse.
- mul_product  in  2*DATA_WIDTH  core result, valid when mul_done=1.
- busy  out  1  state != IDLE.
- jobs_done  out  CNT_WIDTH  completed-response counter, wraps.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, all outputs 0 (req_ready, rsp_valid, rsp_product, rsp_err, mul_start, mul_a, mul_b, mul_signed, busy, jobs_done). Reset mid-operation abandons the job: no response, no start, and a mul_done on the reset cycle is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: one-hot of the first k with req_valid[k]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. It is 0 if no request or if state != IDLE.
  - On a handshake: register that requester's operands to mul_a/mul_b/mul_signed, store grant index g, rr_ptr <= (g+1) mod NUM_REQ, go to ISSUE.
- ISSUE: mul_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - On mul_done=1: capture mul_product to rsp_product, rsp_err=0, go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): rsp_product=0, rsp_err=1, go to RESP.
  - mul_done on the same cycle as expiry: done wins, no error.
- RESP:
  - rsp_valid[g]=1, registered and held with rsp_product/rsp_err stable until rsp_ready[g]=1.
  - On handshake: rsp_valid -> 0, jobs_done += 1 (also counts errors; wraps at 2^CNT_WIDTH), go to IDLE.
  - rsp_ready of non-granted requesters is ignored.
- mul_done outside WAIT is ignored (spurious).
- mul_a/mul_b/mul_signed hold their value from capture until the next capture.
- Minimum latency:
  - accept at cycle 0, mul_start at 1.
  - mul_done at cycle 1+L (L≥1) gives rsp_valid at 2+L.
  - Next accept no earlier than one cycle after the response handshake (IDLE re-entered).
- Fairness: each requester that holds req_valid is granted within NUM_REQ jobs.
- A requester may drop req_valid before its grant without side effect.
- The scheduler does not check operand widths; sign handling is the core's.

Decomposition:
- Package mult_sched_pkg: state enum (IDLE, ISSUE, WAIT, RESP), grant-index width function (clog2 of NUM_REQ, min 1), product-width constant expression.
- One sub-module, mult_rr_arbiter: combinational rotating-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, index, any.
- FSM, operand/result registers, timeout counter and jobs_done live in mult_rr_scheduler.

Test Plan:
- Single job: NUM_REQ=4, req 2 with a=7, b=6, unsigned; core model L=3.
  - Required: mul_start at cycle 1; rsp_valid[2] at cycle 5 with product 42, rsp_err=0; jobs_done=1.
- Signed job: req 0 with a=0xFFFFFFFE (-2), b=3, signed.
  - Required: mul_signed=1 at start; response product 0xFFFFFFFF_FFFFFFFA.
- Round-robin: all four req_valid held high, 4 jobs.
  - Required: grant order 0, 1, 2, 3; then req 1, 3 only give grants 1, 3, 1, 3.
- Timeout: TIMEOUT_CYCLES=8, core never asserts done.
  - Required: rsp_valid with rsp_err=1, product 0, exactly 8 WAIT cycles after ISSUE.
  - Variant: done on expiry cycle gives rsp_err=0.
- Backpressure and spurious done: rsp_ready[g] held low 10 cycles, plus a mul_done pulse injected in IDLE.
  - Required: rsp_valid/product stable for all 10 cycles; no state change or count from the spurious done.
- Reset mid-job: assert ARESET for 1 cycle during WAIT.
  - Required: next cycle all outputs 0, state IDLE, rr_ptr=0; a later done pulse produces no response.
